regfile_sb: RTL and testbench

Parametrised register file with a scoreboard, for the pipelined RISC-V core. It has NUM_READ read ports and one writeback port. x0 is hardwired to zero. Writeback data is forwarded to same-cycle reads, and a per-register pending (busy) scoreboard drives decode-stage hazard stalls. After reset, an internal clear sequencer zeroes the whole array and asserts READY when done. It replaces the flat register file in the decode stage.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_scoreboard.sv | 46 ++++
 rtl/regfile_sb.sv | 70 +++++++
 tb/tb_regfile_sb.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, zero-register index and core-wide default widths
package regfile_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam int ZERO_REG     = 0;
    localparam int A_WIDTH_DEF  = 5;
    localparam int D_WIDTH_DEF  = 32;
    localparam int NUM_READ_DEF = 2;
    localparam int DBG_REG_DEF  = 10;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode-stage bundle of read, writeback, issue and status signals
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int A_WIDTH  = A_WIDTH_DEF,
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int NUM_READ = NUM_READ_DEF
);

    logic                               READY;
    logic [NUM_READ-1:0][A_WIDTH-1:0]   RA;
    logic [NUM_READ-1:0][D_WIDTH-1:0]   RD;
    logic [NUM_READ-1:0]                BUSY;
    logic                               WE;
    logic [A_WIDTH-1:0]                 WA;
    logic [D_WIDTH-1:0]                 WD;
    logic                               ISSUE;
    logic [A_WIDTH-1:0]                 ISSUE_RD;
    logic                               FLUSH;
    logic [D_WIDTH-1:0]                 DBG;

    modport master (
        output RA, WE, WA, WD, ISSUE, ISSUE_RD, FLUSH,
        input  READY, RD, BUSY, DBG
    );

    modport slave (
        input  RA, WE, WA, WD, ISSUE, ISSUE_RD, FLUSH,
        output READY, RD, BUSY, DBG
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with flush/clear/set priority and BUSY lookup
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int A_WIDTH  = A_WIDTH_DEF,
    parameter int NUM_READ = NUM_READ_DEF
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             en,
    input  logic                             issue,
    input  logic [A_WIDTH-1:0]               issue_rd,
    input  logic                             we,
    input  logic [A_WIDTH-1:0]               wa,
    input  logic                             flush,
    input  logic [NUM_READ-1:0][A_WIDTH-1:0] ra,
    output logic [NUM_READ-1:0]              busy
);

    localparam int DEPTH = 2**A_WIDTH;
    localparam logic [A_WIDTH-1:0] ZERO = A_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] nxt;

    // flush first, then writeback clear, then issue set so the younger writer wins
    always_comb begin
        nxt = flush ? '0 : pending;
        if (we && wa != ZERO) nxt[wa] = 1'b0;
        if (issue && issue_rd != ZERO) nxt[issue_rd] = 1'b1;
        nxt[ZERO_REG] = 1'b0;
    end

    // pending vector only moves while the register file is running
    always_ff @(posedge CLK) begin
        if (!RST_N) pending <= '0;
        else if (en) pending <= nxt;
    end

    // a same-cycle writeback to the read register is resolved by forwarding
    always_comb begin
        for (int i = 0; i < NUM_READ; i++)
            busy[i] = en && pending[ra[i]] && !(we && wa == ra[i]);
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with x0, writeback forwarding, clear-after-reset sequencer and hazard scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int A_WIDTH  = A_WIDTH_DEF,
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int NUM_READ = NUM_READ_DEF,
    parameter int DBG_REG  = DBG_REG_DEF
) (
    input  logic         CLK,
    input  logic         RST_N,
    regfile_sb_if.slave  bus
);

    localparam int DEPTH = 2**A_WIDTH;
    localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(DEPTH-1);
    localparam logic [A_WIDTH-1:0] ZERO = A_WIDTH'(ZERO_REG);

    state_t              state;
    logic [A_WIDTH-1:0]  cnt;
    logic [D_WIDTH-1:0]  regs [DEPTH];
    logic                run;
    logic                wr;

    assign run       = state == RUN;
    assign wr        = run && bus.WE && bus.WA != ZERO;
    assign bus.READY = run;
    assign bus.DBG   = run ? regs[DBG_REG] : '0;

    // clear sequencer: walk every address once after reset, then run
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= INIT;
            cnt   <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= RUN;
        end
    end

    // array: zeroed by the sequencer during INIT, written back in RUN
    always_ff @(posedge CLK) begin
        if (RST_N && !run) regs[cnt] <= '0;
        else if (wr) regs[bus.WA] <= bus.WD;
    end

    // read ports: x0 reads zero, same-cycle writeback data bypasses the array
    always_comb begin
        for (int i = 0; i < NUM_READ; i++)
            bus.RD[i] = (!run || bus.RA[i] == ZERO) ? '0 :
                        (wr && bus.WA == bus.RA[i]) ? bus.WD : regs[bus.RA[i]];
    end

    regfile_scoreboard #(
        .A_WIDTH  (A_WIDTH),
        .NUM_READ (NUM_READ)
    ) u_sb (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .en       (run),
        .issue    (run && bus.ISSUE),
        .issue_rd (bus.ISSUE_RD),
        .we       (wr),
        .wa       (bus.WA),
        .flush    (run && bus.FLUSH),
        .ra       (bus.RA),
        .busy     (bus.BUSY)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed scoreboard bench against a behavioural register-file model
module tb_regfile_sb;

    localparam int DEPTH = 32;

    typedef struct {
        int              tag;
        logic            ready;
        logic [31:0]     dbg;
        logic [1:0][31:0] rd;
        logic [1:0]      busy;
    } exp_t;

    logic clk;
    logic rst_n;

    regfile_sb_if #(.A_WIDTH(5), .D_WIDTH(32), .NUM_READ(2)) bus ();

    regfile_sb #(.A_WIDTH(5), .D_WIDTH(32), .NUM_READ(2), .DBG_REG(10)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    exp_t         q [$];
    logic [31:0]  mem [DEPTH];
    bit [DEPTH-1:0] pend;
    int           since;
    int           ncyc;
    int           errors;
    int           checks;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, tag, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("READY", e.tag, 32'(bus.READY), 32'(e.ready));
            chk("DBG", e.tag, bus.DBG, e.dbg);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("RD[%0d]", i), e.tag, bus.RD[i], e.rd[i]);
                chk($sformatf("BUSY[%0d]", i), e.tag, 32'(bus.BUSY[i]), 32'(e.busy[i]));
            end
        end
    end

    task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic iss, input logic [4:0] ird, input logic fl,
                        input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t e;
        logic [4:0] ra [2];
        rst_n = r;
        bus.WE = we;
        bus.WA = wa;
        bus.WD = wd;
        bus.ISSUE = iss;
        bus.ISSUE_RD = ird;
        bus.FLUSH = fl;
        bus.RA[0] = ra0;
        bus.RA[1] = ra1;
        ra[0] = ra0;
        ra[1] = ra1;
        e.tag = ncyc;
        e.ready = since >= DEPTH;
        e.dbg = e.ready ? mem[10] : 32'h0;
        for (int i = 0; i < 2; i++) begin
            e.rd[i] = (!e.ready || ra[i] == 0) ? 32'h0 : (we && wa == ra[i]) ? wd : mem[ra[i]];
            e.busy[i] = e.ready && pend[ra[i]] && !(we && wa == ra[i]);
        end
        q.push_back(e);
        @(posedge clk);
        if (!r) begin
            since = 0;
            pend = '0;
        end else if (since < DEPTH) begin
            since++;
            if (since == DEPTH)
                for (int k = 0; k < DEPTH; k++) mem[k] = 32'h0;
        end else begin
            if (fl) pend = '0;
            if (we && wa != 0) begin
                mem[wa] = wd;
                pend[wa] = 1'b0;
            end
            if (iss && ird != 0) pend[ird] = 1'b1;
        end
        #1;
        ncyc++;
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        step(1, 0, 0, 0, 0, 0, 0, ra0, ra1);
    endtask

    task automatic rand_step(input logic r);
        step(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
             1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 15)), 1'($urandom_range(0, 31) == 0),
             5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ncyc = 0;
        since = 0;
        pend = '0;
        rst_n = 0;
        bus.WE = 0;
        bus.WA = 0;
        bus.WD = 0;
        bus.ISSUE = 0;
        bus.ISSUE_RD = 0;
        bus.FLUSH = 0;
        bus.RA = '0;
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < DEPTH; c++) step(1, 1, 5'(c), 32'hFFFF_0000 | c, 1, 5'(c), 0, 5'(c), 5'(c + 1));
        for (int k = 0; k < DEPTH; k += 2) idle(5'(k), 5'(k + 1));
        step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        idle(5, 0);
        step(1, 1, 0, 32'h1234, 0, 0, 0, 5, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(0, 0);
        step(1, 0, 0, 0, 1, 7, 0, 0, 0);
        idle(7, 0);
        step(1, 1, 7, 32'h55, 0, 0, 0, 7, 7);
        step(1, 1, 7, 32'h66, 1, 7, 0, 7, 0);
        idle(7, 7);
        step(1, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 0, 0, 0, 1, 4, 0, 0, 0);
        step(1, 0, 0, 0, 1, 9, 0, 3, 4);
        step(1, 0, 0, 0, 1, 4, 1, 9, 4);
        idle(3, 4);
        idle(9, 7);
        for (int n = 0; n < 400; n++) rand_step(1);
        step(1, 1, 10, 32'hA5, 0, 0, 0, 10, 0);
        step(1, 0, 0, 0, 1, 10, 0, 10, 0);
        step(1, 0, 0, 0, 1, 12, 0, 10, 12);
        step(0, 1, 10, 32'h77, 1, 13, 0, 10, 12);
        for (int c = 0; c < DEPTH; c++) rand_step(1);
        for (int k = 0; k < DEPTH; k += 2) idle(5'(k), 5'(k + 1));
        for (int n = 0; n < 200; n++) rand_step(1);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
